a2_bridge_arbiter: RTL
======================

# a2_bridge_arbiter

Sequencer and arbiter for the shared multiplexed Apple II bus bridge (3-bit select, RD_N/WR_N strobes, 8-bit bidirectional data). It accepts single-byte read/write commands from four requesters and grants the bridge to one at a time: requester 0 has absolute priority, requesters 1–3 are served round-robin. It generates the setup/strobe/hold sequence on the bridge pins and returns read data. When no command is active, it continuously samples the idle select (control lines) for the rest of the bus logic.

## Interface
- `SETUP_CYCLES`, default 1: cycles with select and data driven before the strobe (legal 1–15).
- `STROBE_CYCLES`, default 1: cycles with RD_N/WR_N asserted (legal 1–15).
- `HOLD_CYCLES`, default 1: cycles after the strobe with select and data held (legal 1–15).
- `IDLE_SEL`, default 3'd0: bridge select driven and read while idle.

Ports:
- `clk_logic_i`, in, 1: sole clock; all logic on the rising edge.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `req_i`, in, 4: per-requester command request (level).
- `req_sel_i`, in, 12: 3-bit bridge select per requester; requester n uses bits [3n+2:3n].
- `req_we_i`, in, 4: 1 = write, 0 = read, per requester.
- `req_wdata_i`, in, 32: write byte per requester; requester n uses bits [8n+7:8n].
- `gnt_o`, out, 4: one-hot, one-cycle grant pulse.
- `done_o`, out, 4: one-hot, one-cycle completion pulse.
- `rdata_o`, out, 8: read byte of the last completed read.
- `busy_o`, out, 1: high whenever state ≠ IDLE.
- `ctrl_data_o`, out, 8: last byte sampled at `IDLE_SEL` while idle.
- `ctrl_valid_o`, out, 1: one-cycle pulse when `ctrl_data_o` updates.
- `a2_bridge_sel_o`, out, 3: bridge select.
- `a2_bridge_rd_n_o`, out, 1: bridge read strobe, active low.
- `a2_bridge_wr_n_o`, out, 1: bridge write strobe, active low.
- `a2_bridge_d_o`, out, 8: bridge write data.
- `a2_bridge_d_oe_o`, out, 1: bridge data output enable.
- `a2_bridge_d_i`, in, 8: bridge read data.

## Operation
**Reset values:**
- State is IDLE. The round-robin pointer is set to 1.
- `a2_bridge_sel_o`=`IDLE_SEL`, `a2_bridge_rd_n_o`=1, `a2_bridge_wr_n_o`=1, `a2_bridge_d_o`=0, `a2_bridge_d_oe_o`=0.
- `gnt_o`=0, `done_o`=0, `rdata_o`=0, `busy_o`=0, `ctrl_data_o`=8'hFF, `ctrl_valid_o`=0.
- Reset asserted mid-transaction aborts it immediately, with no `done_o` and no further strobe.

**States:** IDLE → SETUP → STROBE → HOLD → IDLE. A single 4-bit down-counter, reloaded on each state entry, times every phase.

**IDLE:**
- Drives sel=`IDLE_SEL`, rd_n=0, wr_n=1, d_oe=0.
- On every IDLE cycle whose previous cycle was also IDLE: `ctrl_data_o` ← `a2_bridge_d_i` and `ctrl_valid_o` pulses.
- The first IDLE cycle after reset or after HOLD does not sample.

**Arbitration (evaluated in IDLE only):**
- If `req_i[0]` is set, requester 0 wins.
- Otherwise the winner is the first set bit among 1–3, searching from the pointer upward and wrapping 3→1.
- After a winner w in 1–3 is granted, the pointer becomes w+1, wrapping 3→1. A requester-0 win leaves the pointer unchanged.
- On a win: the winner's sel, we and wdata are latched, `gnt_o[w]` is high in the first SETUP cycle, and the state moves to SETUP.
- `req_i` is ignored outside IDLE. A requester drops `req_i` on seeing `gnt_o`; a request still high at the next IDLE evaluation is a new command.

**SETUP:**
- Drives sel=latched sel, rd_n=1, wr_n=1.
- Write: d_o=wdata, d_oe=1. Read: d_oe=0.

**STROBE:**
- Select and data unchanged.
- Read: rd_n=0. Write: wr_n=0.
- Read data is captured into `rdata_o` on the clock edge that leaves STROBE.

**HOLD:**
- rd_n=1, wr_n=1; select, d_o and d_oe held.
- Leaving HOLD: d_oe=0, sel=`IDLE_SEL`, and `done_o[w]` pulses in the first IDLE cycle.

`rdata_o` is held until the next read completes; writes leave it unchanged.

## Timing
- Latency from request (req seen in IDLE at cycle 0) to completion: `gnt_o` at cycle 1; `done_o` at cycle 1+SETUP+STROBE+HOLD (defaults: cycle 4).
- Back-to-back: the next grant can be decided in the same IDLE cycle that carries `done_o`, so the next SETUP starts one cycle later. The default rate is one transaction per 4 cycles.
- All outputs are registered; no combinational path from `req_i` or `a2_bridge_d_i` to any output.
- rd_n and wr_n are never low in the same cycle.
- wr_n is only low while d_oe=1 and select is stable.
- Simultaneous requests on all four ports: requester 0 wins every time it is asserted; 1–3 rotate in the gaps.

## Test plan
- **Read after reset:** reset, then req_i=4'b0010, sel=3'd2, we=0, bridge returns 8'hA5 on sel 2 → `gnt_o`=4'b0010 at cycle 1, rd_n low only in cycle 2, `done_o[1]` and `rdata_o`=8'hA5 at cycle 4.
- **Write:** requester 3 writes 8'h5A to sel 1 → d_oe=1 with d_o=8'h5A in cycles 1–3, wr_n low in cycle 2 only, rd_n=1 throughout, `rdata_o` unchanged.
- **Round-robin:** req_i held at 4'b1110 → grant order 1,2,3,1,2,3.
- **Priority:** req_i=4'b1111 throughout → requester 0 granted every transaction; after dropping bit 0, the order is 1,2,3.
- **Idle sampling:** idle with d_i=8'h3C on `IDLE_SEL` → `ctrl_data_o`=8'h3C and `ctrl_valid_o` pulses from the second idle cycle on; no pulse in the first IDLE cycle after a transaction.
- **Reset mid-operation:** reset asserted during STROBE of a write → bridge outputs return immediately to reset values, no `done_o`; normal operation after release, with pointer=1.

Source files
------------

// File: rtl/a2_bridge_arbiter_if.sv
// Signal bundle between the bridge arbiter, its four requesters and the Apple II bridge pins.
// The arbiter takes the slave modport; the requesters and bridge model take the master modport.
interface a2_bridge_arbiter_if;
  logic [3:0]  req_i;
  logic [11:0] req_sel_i;
  logic [3:0]  req_we_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic [7:0]  rdata_o;
  logic        busy_o;
  logic [7:0]  ctrl_data_o;
  logic        ctrl_valid_o;
  logic [2:0]  a2_bridge_sel_o;
  logic        a2_bridge_rd_n_o;
  logic        a2_bridge_wr_n_o;
  logic [7:0]  a2_bridge_d_o;
  logic        a2_bridge_d_oe_o;
  logic [7:0]  a2_bridge_d_i;

  modport slave (
    input  req_i, req_sel_i, req_we_i, req_wdata_i, a2_bridge_d_i,
    output gnt_o, done_o, rdata_o, busy_o, ctrl_data_o, ctrl_valid_o,
           a2_bridge_sel_o, a2_bridge_rd_n_o, a2_bridge_wr_n_o,
           a2_bridge_d_o, a2_bridge_d_oe_o
  );

  modport master (
    output req_i, req_sel_i, req_we_i, req_wdata_i, a2_bridge_d_i,
    input  gnt_o, done_o, rdata_o, busy_o, ctrl_data_o, ctrl_valid_o,
           a2_bridge_sel_o, a2_bridge_rd_n_o, a2_bridge_wr_n_o,
           a2_bridge_d_o, a2_bridge_d_oe_o
  );
endinterface

// File: rtl/a2_bridge_arbiter.sv
// Four-requester arbiter and setup/strobe/hold sequencer for the multiplexed Apple II bridge.
// Requester 0 has absolute priority, 1-3 rotate; idle cycles sample the control select.
module a2_bridge_arbiter #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter logic [2:0]  IDLE_SEL      = 3'd0
) (
  input  logic               clk_logic_i,
  input  logic               reset_i,
  a2_bridge_arbiter_if.slave bus
);
  localparam int unsigned NUM_REQ = 4;
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] lat_id, lat_id_nxt;
  logic       lat_we, lat_we_nxt;

  logic [3:0] gnt_q, gnt_nxt, done_q, done_nxt;
  logic [7:0] rdata_q, rdata_nxt, ctrl_data_q, ctrl_data_nxt;
  logic       ctrl_valid_q, ctrl_valid_nxt;
  logic [2:0] sel_q, sel_nxt;
  logic       rd_n_q, rd_n_nxt, wr_n_q, wr_n_nxt;
  logic [7:0] d_q, d_nxt;
  logic       d_oe_q, d_oe_nxt;

  logic [NUM_REQ-1:0][2:0] sel_arr;
  logic [NUM_REQ-1:0][7:0] wd_arr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign sel_arr[g] = bus.req_sel_i[3*g +: 3];
    assign wd_arr[g]  = bus.req_wdata_i[8*g +: 8];
  end

  function automatic logic [1:0] rr_inc(input logic [1:0] p);
    return (p == 2'd3) ? 2'd1 : p + 2'd1;
  endfunction

  // Winner: requester 0 first, then 1-3 searched from the pointer with 3->1 wrap.
  logic [1:0] win, c0, c1, c2;
  logic       win_vld;
  always_comb begin
    c0      = ptr;
    c1      = rr_inc(ptr);
    c2      = rr_inc(rr_inc(ptr));
    win     = 2'd0;
    win_vld = 1'b1;
    if (bus.req_i[0])       win = 2'd0;
    else if (bus.req_i[c0]) win = c0;
    else if (bus.req_i[c1]) win = c1;
    else if (bus.req_i[c2]) win = c2;
    else                    win_vld = 1'b0;
  end

  // Outputs are computed for the next cycle and registered, so nothing leaks through combinationally.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ptr_nxt        = ptr;
    lat_id_nxt     = lat_id;
    lat_we_nxt     = lat_we;
    gnt_nxt        = '0;
    done_nxt       = '0;
    rdata_nxt      = rdata_q;
    ctrl_data_nxt  = ctrl_data_q;
    ctrl_valid_nxt = 1'b0;
    sel_nxt        = sel_q;
    rd_n_nxt       = 1'b1;
    wr_n_nxt       = 1'b1;
    d_nxt          = d_q;
    d_oe_nxt       = d_oe_q;
    case (state)
      IDLE: begin
        sel_nxt  = IDLE_SEL;
        rd_n_nxt = 1'b0;
        d_oe_nxt = 1'b0;
        if (win_vld) begin
          state_nxt    = SETUP;
          cnt_nxt      = SETUP_LD;
          gnt_nxt[win] = 1'b1;
          lat_id_nxt   = win;
          lat_we_nxt   = bus.req_we_i[win];
          sel_nxt      = sel_arr[win];
          rd_n_nxt     = 1'b1;
          d_oe_nxt     = bus.req_we_i[win];
          if (bus.req_we_i[win]) d_nxt = wd_arr[win];
          if (win != 2'd0) ptr_nxt = rr_inc(win);
        end else begin
          // Staying idle: the following cycle is an idle-after-idle cycle carrying this sample.
          ctrl_data_nxt  = bus.a2_bridge_d_i;
          ctrl_valid_nxt = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = STROBE;
          cnt_nxt   = STROBE_LD;
          rd_n_nxt  = lat_we;
          wr_n_nxt  = ~lat_we;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
          if (!lat_we) rdata_nxt = bus.a2_bridge_d_i;
        end else begin
          cnt_nxt  = cnt - 4'd1;
          rd_n_nxt = lat_we;
          wr_n_nxt = ~lat_we;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_nxt        = IDLE;
          done_nxt[lat_id] = 1'b1;
          sel_nxt          = IDLE_SEL;
          rd_n_nxt         = 1'b0;
          d_oe_nxt         = 1'b0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= 2'd1;
      lat_id       <= '0;
      lat_we       <= 1'b0;
      gnt_q        <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      ctrl_data_q  <= 8'hFF;
      ctrl_valid_q <= 1'b0;
      sel_q        <= IDLE_SEL;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      d_q          <= '0;
      d_oe_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ptr          <= ptr_nxt;
      lat_id       <= lat_id_nxt;
      lat_we       <= lat_we_nxt;
      gnt_q        <= gnt_nxt;
      done_q       <= done_nxt;
      rdata_q      <= rdata_nxt;
      ctrl_data_q  <= ctrl_data_nxt;
      ctrl_valid_q <= ctrl_valid_nxt;
      sel_q        <= sel_nxt;
      rd_n_q       <= rd_n_nxt;
      wr_n_q       <= wr_n_nxt;
      d_q          <= d_nxt;
      d_oe_q       <= d_oe_nxt;
    end
  end

  assign bus.gnt_o            = gnt_q;
  assign bus.done_o           = done_q;
  assign bus.rdata_o          = rdata_q;
  assign bus.busy_o           = (state != IDLE);
  assign bus.ctrl_data_o      = ctrl_data_q;
  assign bus.ctrl_valid_o     = ctrl_valid_q;
  assign bus.a2_bridge_sel_o  = sel_q;
  assign bus.a2_bridge_rd_n_o = rd_n_q;
  assign bus.a2_bridge_wr_n_o = wr_n_q;
  assign bus.a2_bridge_d_o    = d_q;
  assign bus.a2_bridge_d_oe_o = d_oe_q;
endmodule
